// File: rtl/sequenciador_entrada.sv
// sequenciador_entrada: keypad entry sequencer that writes digits to the entry memory and selects the function on confirm
module sequenciador_entrada #(
    parameter int N_DIGITOS      = 4,
    parameter int ADDR_W         = 2,
    parameter int TIMEOUT_CICLOS = 50000000,
    parameter int TIMEOUT_W      = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              habilita,
    input  logic              tecla_valida,
    input  logic [3:0]        tecla,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_dado,
    output logic              funcao_selecionada,
    output logic [1:0]        funcao,
    output logic [ADDR_W:0]   contagem,
    output logic              erro_entrada,
    output logic              timeout,
    output logic [2:0]        db_estado
);
    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        ESPERA    = 3'd1,
        ESCREVE   = 3'd2,
        SELECIONA = 3'd3,
        AGUARDA   = 3'd4
    } estado_t;

    localparam logic [ADDR_W:0]    N_MAX = (ADDR_W+1)'(N_DIGITOS);
    localparam logic [TIMEOUT_W-1:0] T_FIM = TIMEOUT_W'(TIMEOUT_CICLOS - 1);

    estado_t             estado, estado_prox;
    logic [TIMEOUT_W-1:0] timer, timer_prox;
    logic [ADDR_W:0]     contagem_prox;
    logic [ADDR_W-1:0]   addr_prox;
    logic [3:0]          dado_prox;
    logic [1:0]          funcao_prox;
    logic                erro_prox, timeout_prox;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= OCIOSO;
            timer        <= '0;
            contagem     <= '0;
            mem_addr     <= '0;
            mem_dado     <= '0;
            funcao       <= 2'b00;
            erro_entrada <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            estado       <= estado_prox;
            timer        <= timer_prox;
            contagem     <= contagem_prox;
            mem_addr     <= addr_prox;
            mem_dado     <= dado_prox;
            funcao       <= funcao_prox;
            erro_entrada <= erro_prox;
            timeout      <= timeout_prox;
        end
    end

    always_comb begin
        estado_prox   = OCIOSO;
        timer_prox    = timer;
        contagem_prox = contagem;
        addr_prox     = mem_addr;
        dado_prox     = mem_dado;
        funcao_prox   = funcao;
        erro_prox     = 1'b0;
        timeout_prox  = 1'b0;
        case (estado)
            OCIOSO: begin
                estado_prox = habilita ? ESPERA : OCIOSO;
                if (habilita) begin
                    contagem_prox = '0;
                    timer_prox    = '0;
                end
            end
            ESPERA: begin
                estado_prox = ESPERA;
                if (!habilita) begin
                    estado_prox   = OCIOSO;
                    contagem_prox = '0;
                    timer_prox    = '0;
                end else if (tecla_valida && tecla <= 4'hD) begin
                    // any accepted key restarts the idle timer and beats a simultaneous expiry
                    timer_prox = '0;
                    if (tecla <= 4'd9) begin
                        if (contagem < N_MAX) begin
                            dado_prox   = tecla;
                            addr_prox   = contagem[ADDR_W-1:0];
                            estado_prox = ESCREVE;
                        end
                    end else if (tecla == 4'hC) begin
                        contagem_prox = (contagem != '0) ? contagem - 1'b1 : contagem;
                    end else if (tecla == 4'hD) begin
                        contagem_prox = '0;
                    end else if (contagem == N_MAX) begin
                        funcao_prox = (tecla == 4'hA) ? 2'b01 : 2'b10;
                        estado_prox = SELECIONA;
                    end else begin
                        erro_prox     = 1'b1;
                        contagem_prox = '0;
                    end
                end else if (contagem == '0) begin
                    timer_prox = '0;
                end else if (timer == T_FIM) begin
                    contagem_prox = '0;
                    timeout_prox  = 1'b1;
                    timer_prox    = '0;
                end else begin
                    timer_prox = timer + 1'b1;
                end
            end
            ESCREVE: begin
                contagem_prox = contagem + 1'b1;
                estado_prox   = ESPERA;
            end
            SELECIONA: estado_prox = AGUARDA;
            AGUARDA: begin
                estado_prox = habilita ? AGUARDA : OCIOSO;
                if (!habilita) begin
                    funcao_prox   = 2'b00;
                    contagem_prox = '0;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    assign mem_we             = (estado == ESCREVE);
    assign funcao_selecionada = (estado == SELECIONA);
    assign db_estado          = estado;
endmodule
